ram32_sdram_ctrl: RTL and testbench
===================================

# ram32_sdram_ctrl

Request-level controller that sits directly upstream of the 32×8 SDRAM-style memory (row/column-multiplexed, active-low `ras`/`cas`, `en`/`rw` access strobe). It accepts whole-address read/write requests over a valid/ready handshake. Each request becomes a RAS → CAS → ACCESS sequence on the memory pins, and reads return data over a one-cycle response pulse. It tracks the open row so that row hits skip the RAS phase, and it can insert periodic refresh activates.

## Interface
- `DATA_W`, 8, data width
- `ROW_W`, 3, row bits (address[4:2])
- `COL_W`, 2, column bits (address[1:0])
- `REFRESH_PERIOD`, 64, cycles between refresh requests (used only with `RAM32_REFRESH_EN`)
- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept; combinational: state==IDLE && !refresh_pending
- `req_rw`  in  1  1 = write, 0 = read (memory polarity)
- `req_addr`  in  5  {row, col}
- `req_wdata`  in  8  write data
- `rsp_valid`  out  1  one-cycle pulse; read data valid or write complete
- `rsp_rdata`  out  8  read data; updated only on reads, held otherwise
- `mem_en`, `mem_rw`, `mem_ras`, `mem_cas`  out  1 each  memory strobes
- `mem_address`  out  5  memory address bus
- `mem_datain`  out  8  memory write data
- `mem_dataout`  in  8  memory read data (registered inside the memory)

## Operation
- Accept on posedge with `req_valid && req_ready`. Capture addr, rw, wdata into request registers.
- States: IDLE, RAS, CAS, ACCESS, RDATA, REF.
- Accept: go to CAS if open_valid && open_row==addr[4:2] (row hit); otherwise go to RAS.
- RAS: `mem_ras`=0, `mem_address`=req addr. Set open_row and open_valid=1. Go to CAS.
- CAS: `mem_cas`=0, `mem_address`=req addr. Go to ACCESS.
- ACCESS: `mem_en`=1, `mem_rw`=req rw, `mem_datain`=wdata, ras=cas=1.
  - Write: set rsp_valid, go to IDLE.
  - Read: go to RDATA.
- RDATA: `mem_en`=0. At the edge, `rsp_rdata`<=`mem_dataout` and rsp_valid is set. Go to IDLE.
- REF: `mem_ras`=0, `mem_address`={ref_row, 2'b00}. ref_row increments mod 8. open_valid is cleared. Go to IDLE.
- IDLE with refresh_pending: go to REF and clear pending. Refresh beats any request; `req_ready` is already low.
- `mem_*` outputs are a decode of the state and request registers. Outside the states above they idle at ras=1, cas=1, en=0. `mem_rw` and `mem_datain` hold their last values.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `mem_ras`=1, `mem_cas`=1, `mem_en`=0, `mem_rw`=0, `mem_address`=0, `mem_datain`=0, open_valid=0, ref_row=0, refresh counter 0, pending 0. `req_ready`=1 in the first cycle after reset release.
- Latency, counted from the accept edge to the cycle in which `rsp_valid` is high:
  - Read miss: 4 edges.
  - Read hit: 3 edges.
  - Write miss: 3 edges.
  - Write hit: 2 edges.
- `rsp_valid` is high for exactly one cycle. No backpressure on responses.
- Back-to-back requests: next accept happens in the cycle `rsp_valid` is high (state is IDLE then).
- Reset mid-sequence: return to IDLE, drop the in-flight request, no `rsp_valid`, open_valid=0. The next access always issues RAS.
- Refresh period elapsing while pending is already set: stays a single pending refresh. Counter restarts.

## Configuration
- `RAM32_REFRESH_EN` defined: compile in the refresh timer, the REF state, and ref_row. A refresh is requested every `REFRESH_PERIOD` cycles.
- Not defined: no REF state, refresh_pending is tied 0, and `req_ready` = state==IDLE. The open row persists until reset.

## Structure
- Package `ram32_ctrl_pkg`: state enum, `DATA_W`/`ROW_W`/`COL_W`/`ADDR_W` constants, row/col slice helpers.
- Sub-module `ram32_refresh_timer`: a counter that produces a sticky pending flag with a clear input. Instantiated only under `RAM32_REFRESH_EN`.

## Test plan
- Write 8'hA5 to 5'h0C, then read 5'h0C → `rsp_rdata`=8'hA5. Read is a row hit: 3-edge latency, no `mem_ras` low.
- After reset, read 5'h1F → RAS issued. `rsp_valid` high on edge 4 with the memory's value.
- Write 5'h03 then 5'h17, back to back → both issue RAS. Readback returns correct data. Second accept happens in the `rsp_valid` cycle of the first.
- Assert `rst_n`=0 during CAS of a read → no `rsp_valid`. `mem_ras`/`mem_cas`=1 and `mem_en`=0 next cycle. Following same-row read issues RAS.
- `RAM32_REFRESH_EN`, `REFRESH_PERIOD`=8, request pending at refresh time → REF issued first with `mem_address`=5'h00 then 5'h04. `req_ready` low until REF completes. The request then goes through RAS (row invalidated).
- Without the macro: 200 idle cycles → `mem_ras` never low.

Source files
------------

// File: rtl/ram32_ctrl_pkg.sv
// ram32_ctrl_pkg: shared types and constants for the ram32 SDRAM-style
// request controller.
//   DATA_W / ROW_W / COL_W / ADDR_W : bus widths (address = {row, col})
//   state_t                         : controller FSM state encoding
//   row_of / col_of                 : address slice helpers
package ram32_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 2;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAS    = 3'd1,
    ST_CAS    = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RDATA  = 3'd4,
    ST_REF    = 3'd5
  } state_t;

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:COL_W];
  endfunction

  function automatic logic [COL_W-1:0] col_of(input logic [ADDR_W-1:0] addr);
    return addr[COL_W-1:0];
  endfunction

endpackage

// File: rtl/ram32_sdram_ctrl_if.sv
// ram32_sdram_ctrl_if: request/response handshake plus memory pin bundle.
//   req_*  : request channel (requester -> controller)
//   rsp_*  : response pulse (controller -> requester)
//   mem_*  : memory strobes, address and data (controller <-> memory)
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester holds req_* stable while valid is
// high and not yet accepted. rsp_valid is a single-cycle pulse with no
// backpressure; the requester must take it in the cycle it is high.
// Modports: slave = controller view, master = requester/memory view.
interface ram32_sdram_ctrl_if;
  import ram32_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_en;
  logic              mem_rw;
  logic              mem_ras;
  logic              mem_cas;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datain;
  logic [DATA_W-1:0] mem_dataout;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, mem_dataout,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_en, mem_rw, mem_ras, mem_cas, mem_address, mem_datain
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, mem_dataout,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_en, mem_rw, mem_ras, mem_cas, mem_address, mem_datain
  );

endinterface

// File: rtl/ram32_refresh_timer.sv
// ram32_refresh_timer: free-running period counter that raises a sticky
// refresh-pending flag every PERIOD cycles.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr_i       : clears the pending flag (a new period elapsing wins)
//   pending_o   : refresh requested and not yet serviced
// Multiple elapsed periods while pending collapse into one request.
module ram32_refresh_timer #(
  parameter int PERIOD = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic pending_o
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(PERIOD - 1));

  always_comb begin
    cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
    pending_d = wrap | (pending_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/ram32_sdram_ctrl.sv
// ram32_sdram_ctrl: turns whole-address read/write requests into
// RAS -> CAS -> ACCESS sequences for a 32x8 row/column multiplexed memory,
// skipping RAS on open-row hits. Reads return data one cycle after ACCESS.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : request/response handshake and memory pins
//   dbg_state_o  : current FSM state
// Build option: define RAM32_REFRESH_EN to add a periodic refresh activate
// (REF state, rotating ref_row) every REFRESH_PERIOD cycles.
module ram32_sdram_ctrl
  import ram32_ctrl_pkg::*;
#(
  parameter int REFRESH_PERIOD = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  ram32_sdram_ctrl_if.slave bus,
  output state_t            dbg_state_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_rw_q, req_rw_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [ROW_W-1:0]  open_row_q, open_row_d;
  logic              open_valid_q, open_valid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  // Last driven values, so address/rw/data hold outside the phases that set them.
  logic [ADDR_W-1:0] addr_hold_q;
  logic              rw_hold_q;
  logic [DATA_W-1:0] datain_hold_q;

  logic              refresh_pending;
  logic [ADDR_W-1:0] ref_addr;
  logic [ADDR_W-1:0] mem_address_w;
  logic              mem_rw_w;
  logic [DATA_W-1:0] mem_datain_w;

`ifdef RAM32_REFRESH_EN
  logic [ROW_W-1:0] ref_row_q, ref_row_d;

  // Pending clears as REF executes; req_ready is already low then.
  ram32_refresh_timer #(.PERIOD(REFRESH_PERIOD)) u_refresh_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == ST_REF),
    .pending_o (refresh_pending)
  );

  assign ref_row_d = (state_q == ST_REF) ? ref_row_q + ROW_W'(1) : ref_row_q;
  assign ref_addr  = {ref_row_q, COL_W'(0)};

  always_ff @(posedge clk) begin
    if (!rst_n) ref_row_q <= '0;
    else        ref_row_q <= ref_row_d;
  end
`else
  // Without the timer no refresh is ever requested; the period is inert.
  assign refresh_pending = 1'b0 && (REFRESH_PERIOD > 0);
  assign ref_addr        = '0;
`endif

  assign bus.req_ready = (state_q == ST_IDLE) && !refresh_pending;

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_rw_d     = req_rw_q;
    req_wdata_d  = req_wdata_q;
    open_row_d   = open_row_q;
    open_valid_d = open_valid_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (refresh_pending) begin
          state_d = ST_REF;
        end else if (bus.req_valid) begin
          req_addr_d  = bus.req_addr;
          req_rw_d    = bus.req_rw;
          req_wdata_d = bus.req_wdata;
          state_d     = (open_valid_q && open_row_q == row_of(bus.req_addr)) ? ST_CAS : ST_RAS;
        end
      end
      ST_RAS: begin
        open_row_d   = row_of(req_addr_q);
        open_valid_d = 1'b1;
        state_d      = ST_CAS;
      end
      ST_CAS: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (req_rw_q) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        // Memory registered its output at the ACCESS edge; capture it now.
        rsp_valid_d = 1'b1;
        rsp_rdata_d = bus.mem_dataout;
        state_d     = ST_IDLE;
      end
      ST_REF: begin
        open_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory pins are a pure decode of the state and request registers.
  always_comb begin
    mem_address_w = addr_hold_q;
    mem_rw_w      = rw_hold_q;
    mem_datain_w  = datain_hold_q;
    case (state_q)
      ST_RAS, ST_CAS: mem_address_w = req_addr_q;
      ST_REF:         mem_address_w = ref_addr;
      ST_ACCESS: begin
        mem_rw_w     = req_rw_q;
        mem_datain_w = req_wdata_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_ras     = !((state_q == ST_RAS) || (state_q == ST_REF));
  assign bus.mem_cas     = !(state_q == ST_CAS);
  assign bus.mem_en      = (state_q == ST_ACCESS);
  assign bus.mem_address = mem_address_w;
  assign bus.mem_rw      = mem_rw_w;
  assign bus.mem_datain  = mem_datain_w;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign dbg_state_o     = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_addr_q    <= '0;
      req_rw_q      <= 1'b0;
      req_wdata_q   <= '0;
      open_row_q    <= '0;
      open_valid_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      addr_hold_q   <= '0;
      rw_hold_q     <= 1'b0;
      datain_hold_q <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      req_rw_q      <= req_rw_d;
      req_wdata_q   <= req_wdata_d;
      open_row_q    <= open_row_d;
      open_valid_q  <= open_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      addr_hold_q   <= mem_address_w;
      rw_hold_q     <= mem_rw_w;
      datain_hold_q <= mem_datain_w;
    end
  end

endmodule

// File: tb/tb_ram32_sdram_ctrl.sv
// tb_ram32_sdram_ctrl: bench for ram32_sdram_ctrl with a pin-level memory
// device, a request driver, and a response monitor fed by an expected queue.
// Build option: RAM32_REFRESH_EN (refresh period shortened to 8).
module tb_ram32_sdram_ctrl;
  import ram32_ctrl_pkg::*;

`ifdef RAM32_REFRESH_EN
  localparam int RP = 8;
`else
  localparam int RP = 64;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram32_sdram_ctrl_if bus();
  state_t dbg_state;

  ram32_sdram_ctrl #(.REFRESH_PERIOD(RP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        is_read;
    logic        exp_ras;
    logic [7:0]  data;
    logic [31:0] cycle;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: flat memory contents and the open row, from the rules.
  logic [7:0] ref_mem [32];
  logic       ref_open_valid = 1'b0;
  logic [2:0] ref_open_row = 3'd0;
  int         drv_ref_seen = 0;

  int ras_cnt = 0;
  int last_ras = 0;
  int ref_idx = 0;
  int ref_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory device ----------------
  logic [7:0] dev_mem [32];
  logic [2:0] dev_row;
  logic [1:0] dev_col;
  logic       init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) dev_mem[i] <= ref_mem[i];
      bus.mem_dataout <= 8'h00;
      dev_row <= 3'd0;
      dev_col <= 2'd0;
    end else begin
      if (!bus.mem_ras) dev_row <= bus.mem_address[4:2];
      if (!bus.mem_cas) dev_col <= bus.mem_address[1:0];
      if (bus.mem_en) begin
        if (bus.mem_rw) dev_mem[{dev_row, dev_col}] <= bus.mem_datain;
        else            bus.mem_dataout <= dev_mem[{dev_row, dev_col}];
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_ras = ras_cnt;
    end else begin
      if (!bus.mem_ras && dbg_state != ST_REF) ras_cnt++;
      if (dbg_state == ST_REF) begin
        check("ref_address", {27'd0, bus.mem_address}, {27'd0, ref_idx[2:0], 2'b00});
        check("ref_req_ready", {31'd0, bus.req_ready}, 32'd0);
        ref_idx++;
        ref_seen++;
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", cyc, e.cycle);
          if (e.is_read) check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e.data});
          check("ras_count", ras_cnt - last_ras, e.exp_ras ? 32'd1 : 32'd0);
          last_ras = ras_cnt;
        end
      end else if (exp_q.size() > 0 && cyc > int'(exp_q[0].cycle)) begin
        e = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL rsp_missing: got no rsp_valid expected one at cycle %0d", e.cycle);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic rw, input logic [4:0] addr, input logic [7:0] wdata,
                        output int acc);
    exp_t e;
    int   w;
    logic hit;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    w = 0;
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_accept: got req_ready=0 for %0d cycles expected acceptance", w);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    if (ref_seen != drv_ref_seen) begin
      ref_open_valid = 1'b0;
      drv_ref_seen   = ref_seen;
    end
    hit       = ref_open_valid && (ref_open_row == addr[4:2]);
    e.is_read = !rw;
    e.exp_ras = !hit;
    e.data    = rw ? 8'h00 : ref_mem[addr];
    // Edges after accept: read 3, write 2, plus 1 for a row miss.
    e.cycle   = 32'(cyc + 1 + (rw ? 2 : 3) + (hit ? 0 : 1));
    exp_q.push_back(e);
    if (rw) ref_mem[addr] = wdata;
    ref_open_valid = 1'b1;
    ref_open_row   = addr[4:2];
    acc = cyc + 1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, acc, start;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'($urandom_range(0, 255));

    repeat (3) @(negedge clk);
    init_done = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    check("rst_mem_ras", {31'd0, bus.mem_ras}, 32'd1);
    check("rst_mem_cas", {31'd0, bus.mem_cas}, 32'd1);
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
    check("rst_mem_address", {27'd0, bus.mem_address}, 32'd0);
    check("rst_mem_datain", {24'd0, bus.mem_datain}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Write then row-hit read of the same address.
    do_req(1'b1, 5'h0C, 8'hA5, acc);
    do_req(1'b0, 5'h0C, 8'h00, acc);
    // Row-miss read of untouched location.
    do_req(1'b0, 5'h1F, 8'h00, acc);
    // Back-to-back write misses: second accept lands in first rsp cycle.
    do_req(1'b1, 5'h03, 8'h3C, a1);
    do_req(1'b1, 5'h17, 8'hC3, a2);
    check("b2b_accept_gap", a2 - a1, 32'd4);
    do_req(1'b0, 5'h03, 8'h00, acc);
    do_req(1'b0, 5'h17, 8'h00, acc);
    drain();

    // Reset during CAS of a read miss.
    do_req(1'b0, 5'h09, 8'h00, acc);
    @(negedge clk);
    @(negedge clk);
    check("cas_before_reset", {31'd0, bus.mem_cas}, 32'd0);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("abort_mem_ras", {31'd0, bus.mem_ras}, 32'd1);
    check("abort_mem_cas", {31'd0, bus.mem_cas}, 32'd1);
    check("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    ref_open_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 5'h0A, 8'h00, acc);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

`ifdef RAM32_REFRESH_EN
    repeat (40) @(negedge clk);
    check("refresh_seen", {31'd0, ref_idx != 0}, 32'd1);
`else
    start = ras_cnt;
    repeat (200) @(negedge clk);
    check("idle_no_ras", ras_cnt - start, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
